// File: rtl/hilo_unit.sv
// HI/LO register unit: MTHI/MTLO, serial shift-add multiplier, and
// sequencing of an external divider through a start/done handshake.
module hilo_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_sign,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        div_done
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_MUL       = 2'd1;
    localparam logic [1:0] S_DIV_START = 2'd2;
    localparam logic [1:0] S_DIV_WAIT  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic [1:0]  state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] div_a_q, div_a_d;
    logic [31:0] div_b_q, div_b_d;
    logic        div_sign_q, div_sign_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic        neg_q, neg_d;
    logic [5:0]  cnt_q, cnt_d;

    logic        mul_signed;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [63:0] mul_sum;
    logic [63:0] prod;

    always_comb begin
        mul_signed = (op == OP_MULT);
        rs_mag = (mul_signed && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
        rt_mag = (mul_signed && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
        mul_sum = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
        prod = neg_q ? (64'd0 - mul_sum) : mul_sum;

        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_a_d    = div_a_q;
        div_b_d    = div_b_q;
        div_sign_d = div_sign_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        neg_d      = neg_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        OP_MULT, OP_MULTU: begin
                            mcand_d  = {32'd0, rs_mag};
                            mplier_d = rt_mag;
                            acc_d    = 64'd0;
                            cnt_d    = 6'd0;
                            neg_d    = mul_signed & (rs_val[31] ^ rt_val[31]);
                            state_d  = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero never reaches the divider.
                            if (rt_val == 32'd0) begin
                                hi_d = rs_val;
                                lo_d = 32'hFFFF_FFFF;
                            end else begin
                                div_a_d    = rs_val;
                                div_b_d    = rt_val;
                                div_sign_d = (op == OP_DIV);
                                state_d    = S_DIV_START;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = S_IDLE;
                end
            end
            S_DIV_START: state_d = S_DIV_WAIT;
            S_DIV_WAIT: begin
                if (div_done) begin
                    hi_d    = div_r;
                    lo_d    = div_q;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            div_a_q    <= 32'd0;
            div_b_q    <= 32'd0;
            div_sign_q <= 1'b0;
            mcand_q    <= 64'd0;
            mplier_q   <= 32'd0;
            acc_q      <= 64'd0;
            neg_q      <= 1'b0;
            cnt_q      <= 6'd0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_a_q    <= div_a_d;
            div_b_q    <= div_b_d;
            div_sign_q <= div_sign_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            neg_q      <= neg_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign div_start = (state_q == S_DIV_START);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign div_sign  = div_sign_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with a behavioural 32-iteration divider
// whose done level rises 33 edges after it samples div_start.
module tb_hilo_unit;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_sign;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        div_done;

    int errors = 0;
    int checks = 0;

    hilo_unit dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_sign(div_sign), .div_q(div_q), .div_r(div_r),
        .div_done(div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: counter loaded on the start edge, done when it hits 0.
    int  dv_cnt;
    bit  dv_run;
    always @(posedge clk) begin
        if (!rst_n) begin
            dv_run <= 1'b0;
            dv_cnt <= 0;
        end else if (div_start) begin
            dv_run <= 1'b1;
            dv_cnt <= 32;
        end else if (dv_run && dv_cnt == 0) begin
            dv_run <= 1'b0;
        end else if (dv_run) begin
            dv_cnt <= dv_cnt - 1;
        end
    end
    assign div_done = dv_run && (dv_cnt == 0);
    always_comb begin
        div_q = 32'd0;
        div_r = 32'd0;
        if (div_b != 32'd0) begin
            if (div_sign) begin
                div_q = $signed(div_a) / $signed(div_b);
                div_r = $signed(div_a) % $signed(div_b);
            end else begin
                div_q = div_a / div_b;
                div_r = div_a % div_b;
            end
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int bc,
                          output int sc, output bit stab, output bit to);
        logic [31:0] ra, rb;
        logic        rsg;
        @(negedge clk);
        op_valid = 1'b1;
        op = o;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op = 3'b000;
        bc = 0;
        sc = 0;
        stab = 1'b1;
        ra = div_a;
        rb = div_b;
        rsg = div_sign;
        for (int i = 0; i < 200 && busy; i++) begin
            bc++;
            if (div_start) sc++;
            if (div_a !== ra || div_b !== rb || div_sign !== rsg) stab = 1'b0;
            @(posedge clk);
            #1;
        end
        to = busy;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        op_valid = 1'b1;
        op = 3'b101;
        rs_val = 32'hDEAD_BEEF;
        rt_val = 32'd1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, div_start, div_sign} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl got %b want 000", {busy, div_start, div_sign});
        end
        checks++;
        if ({hi, lo, div_a, div_b} !== 128'd0) begin
            errors++;
            $display("FAIL reset_regs got %h %h %h %h want 0", hi, lo, div_a, div_b);
        end
        op_valid = 1'b0;
        op = 3'b000;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mthi_mtlo;
        int  bc, sc;
        bit  st, to;
        run_op(3'b101, 32'h1234_5678, 32'd0, bc, sc, st, to);
        checks++;
        if (bc !== 0 || hi !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mthi busy=%0d hi=%h want 0 12345678", bc, hi);
        end
        run_op(3'b110, 32'h9ABC_DEF0, 32'd0, bc, sc, st, to);
        checks++;
        if (bc !== 0 || lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mtlo busy=%0d hi=%h lo=%h want 0 12345678 9abcdef0", bc, hi, lo);
        end
    endtask

    task automatic test_nop;
        int  bc, sc;
        bit  st, to;
        run_op(3'b000, 32'h1111_1111, 32'd3, bc, sc, st, to);
        run_op(3'b111, 32'h2222_2222, 32'd3, bc, sc, st, to);
        checks++;
        if (bc !== 0 || hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL nop busy=%0d hi=%h lo=%h want unchanged", bc, hi, lo);
        end
    endtask

    task automatic test_mult;
        int  bc, sc;
        bit  st, to;
        run_op(3'b001, 32'hFFFF_FFFD, 32'd7, bc, sc, st, to);
        checks++;
        if (to || bc !== 32) begin
            errors++;
            $display("FAIL mult_busy got %0d timeout=%0d want 32", bc, to);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mult got %h_%h want ffffffff_ffffffeb", hi, lo);
        end
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, sc, st, to);
        checks++;
        if (to || bc !== 32 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu busy=%0d got %h_%h want 32 fffffffe_00000001", bc, hi, lo);
        end
    endtask

    task automatic test_div;
        int  bc, sc;
        bit  st, to;
        run_op(3'b011, 32'hFFFF_FFF9, 32'd2, bc, sc, st, to);
        checks++;
        if (to || bc !== 34 || sc !== 1) begin
            errors++;
            $display("FAIL div_timing busy=%0d starts=%0d to=%0d want 34 1", bc, sc, to);
        end
        checks++;
        if (!st) begin
            errors++;
            $display("FAIL div_operands_stable got unstable want stable");
        end
        checks++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div got hi=%h lo=%h want ffffffff fffffffd", hi, lo);
        end
        run_op(3'b100, 32'd100, 32'd7, bc, sc, st, to);
        checks++;
        if (to || bc !== 34 || lo !== 32'd14 || hi !== 32'd2 || div_sign !== 1'b0) begin
            errors++;
            $display("FAIL divu busy=%0d hi=%0d lo=%0d sign=%b want 34 2 14 0", bc, hi, lo, div_sign);
        end
    endtask

    task automatic test_div_zero;
        int  bc, sc;
        bit  st, to;
        run_op(3'b100, 32'h55, 32'd0, bc, sc, st, to);
        checks++;
        if (bc !== 0 || div_start !== 1'b0 || hi !== 32'h55 || lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_zero busy=%0d start=%b hi=%h lo=%h want 0 0 55 ffffffff", bc, div_start, hi, lo);
        end
        @(posedge clk);
        #1;
        checks++;
        if (div_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL div_zero_late start=%b busy=%b want 0 0", div_start, busy);
        end
    endtask

    task automatic test_busy_ignore;
        int bc;
        int hold;
        @(negedge clk);
        op_valid = 1'b1;
        op = 3'b011;
        rs_val = 32'd100;
        rt_val = 32'd7;
        @(posedge clk);
        #1;
        op = 3'b101;
        rs_val = 32'h0000_AAAA;
        hold = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy) hold++;
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;
        op = 3'b000;
        bc = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            bc++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy || hold !== 6 || bc !== 28) begin
            errors++;
            $display("FAIL ignore_timing hold=%0d rest=%0d busy=%b want 6 28 0", hold, bc, busy);
        end
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL ignore_mthi got hi=%h lo=%h want 2 e", hi, lo);
        end
    endtask

    task automatic test_reset_abort;
        int  bc, sc;
        bit  st, to;
        @(negedge clk);
        op_valid = 1'b1;
        op = 3'b001;
        rs_val = 32'd5;
        rt_val = 32'd6;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op = 3'b000;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL abort busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0) begin
            errors++;
            $display("FAIL abort_hold busy=%b hi=%h want 0 0", busy, hi);
        end
        run_op(3'b100, 32'd9, 32'd3, bc, sc, st, to);
        checks++;
        if (to || bc !== 34 || sc !== 1 || lo !== 32'd3 || hi !== 32'd0) begin
            errors++;
            $display("FAIL post_abort_divu busy=%0d starts=%0d hi=%h lo=%h want 34 1 0 3", bc, sc, hi, lo);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        op_valid = 1'b0;
        op = 3'b000;
        rs_val = 32'd0;
        rt_val = 32'd0;
        test_reset;
        test_mthi_mtlo;
        test_nop;
        test_mult;
        test_div;
        test_div_zero;
        test_busy_ignore;
        test_reset_abort;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports in this order:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- op_valid  in  1  operation request, sampled on rising edge
- op  in  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved
- rs_val  in  32  operand A (dividend / multiplicand / MTHI/MTLO source)
- rt_val  in  32  operand B (divisor / multiplier)
- busy  out  1  multi-cycle operation in progress; pipeline stall request
- hi  out  32  HI register (MFHI source)
- lo  out  32  LO register (MFLO source)
- div_start  out  1  one-cycle start pulse to the divider
- div_a  out  32  dividend to the divider
- div_b  out  32  divisor to the divider
- div_sign  out  1  1 = signed divide
- div_q  in  32  divider quotient
- div_r  in  32  divider remainder
- div_done  in  1  divider completion level

Function
REQ-002 State machine SHALL have states IDLE, MUL, DIV_START, DIV_WAIT; busy = (state != IDLE).
REQ-003 Requests SHALL be accepted only in IDLE with op_valid=1; op_valid while busy SHALL be ignored, never queued.
REQ-004 NOP and op=111 SHALL change no state and no register.
REQ-005 MTHI SHALL write hi <= rs_val on the accepting edge; MTLO SHALL write lo <= rs_val; busy SHALL stay 0.
REQ-006 MULT/MULTU accept SHALL register operand magnitudes (two's-complement negate if signed and negative) and the result sign (rs[31]^rt[31] & signed), then enter MUL.
REQ-007 MUL SHALL perform one shift-add iteration per cycle, 32 iterations, using a 6-bit counter.
REQ-008 On the 32nd edge after acceptance, {hi,lo} SHALL receive the 64-bit product, negated in 64 bits when the result sign is 1; state returns to IDLE; busy is high for exactly 32 cycles.
REQ-009 DIV/DIVU with rt_val != 0 SHALL latch div_a=rs_val, div_b=rt_val, div_sign=(op==DIV) and enter DIV_START.
REQ-010 div_start SHALL be 1 only in DIV_START, for exactly one cycle; next state is DIV_WAIT unconditionally.
REQ-011 div_a, div_b and div_sign SHALL remain stable from acceptance until the capture edge, because the divider reads them combinationally at completion.
REQ-012 DIV_WAIT SHALL ignore div_done in no cycle. On the first edge with div_done=1, it SHALL set hi <= div_r and lo <= div_q and return to IDLE.
REQ-013 With a 32-iteration divider (done set 33 edges after the start pulse is sampled), hi/lo SHALL update at the 34th edge after acceptance; busy is high 34 cycles.
REQ-014 DIV/DIVU with rt_val == 0 SHALL bypass the divider: hi <= rs_val and lo <= 32'hFFFFFFFF on the accepting edge, busy stays 0, div_start stays 0.
REQ-015 Any write to hi or lo SHALL be visible on the outputs the cycle after the writing edge.
REQ-016 The block SHALL NOT impose a timeout; DIV_WAIT holds until div_done.

Reset
REQ-017 With rst_n=0 at a rising edge, the block SHALL set state=IDLE, hi=0, lo=0, busy=0, div_start=0, div_a=0, div_b=0, div_sign=0, and clear the multiplier counter and accumulators.
REQ-018 Reset SHALL take priority over op_valid and over any in-flight MUL/DIV operation. An aborted divide SHALL leave hi/lo at 0, and the divider is re-armed by the next div_start.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Reset, then MTHI rs=0x12345678 and MTLO rs=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0, busy never 1.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> busy for 32 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 with the divider attached -> one div_start pulse, busy for 34 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
- DIVU rs=0x55, rt=0 -> same edge hi=0x55, lo=0xFFFFFFFF, div_start never 1.
- During DIV busy, op_valid=1 with MTHI 0xAAAA -> ignored: hi equals the divide remainder, not 0xAAAA.
- rst_n=0 on cycle 10 of a MULT -> next cycle busy=0, hi=lo=0; a following DIVU 9/3 completes with lo=3, hi=0.
